ice40_rst_seq: RTL



---
 rtl/ice40_rst_pkg.sv | 23 ++
 rtl/ice40_rst_sync.sv | 24 ++
 rtl/ice40_rst_seq.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ice40_rst_pkg.sv
// Shared definitions for the staged reset sequencer:
// FSM state encodings, parameter limits, counter-width helper.
package ice40_rst_pkg;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_STAGE = 2'd1,
    S_DONE  = 2'd2
  } rst_state_e;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 8;
  localparam int MIN_DLY    = 1;
  localparam int MAX_DLY    = 65535;

  // Width able to hold 0..max(a,b)-1, never below 1 bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ice40_rst_sync.sv
// 2-flop reset synchronizer: async assert, sync deassert.
// Ports: clk, i_arst_n (raw reset), o_srst_n (synchronized reset).
module ice40_rst_sync (
  input  logic clk,
  input  logic i_arst_n,
  output logic o_srst_n
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= 1'b1;
      r_s2 <= r_s1;
    end
  end

  assign o_srst_n = r_s2;

endmodule

// File: rtl/ice40_rst_seq.sv
// Staged reset sequencer: ordered, delayed releases of N reset
// outputs, software re-sequence, optional watchdog (ICE40_RST_WDT_EN).
// Ports: clk, resetn, sw_rst_req, wdt_kick -> rst_n_out[N_STAGES],
// rst_done, rst_busy, wdt_fired.
module ice40_rst_seq
  import ice40_rst_pkg::*;
#(
  parameter int N_STAGES  = 3,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_DLY = 8,
  parameter int WDT_CYC   = 1000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                sw_rst_req,
  input  logic                wdt_kick,
  output logic [N_STAGES-1:0] rst_n_out,
  output logic                rst_done,
  output logic                rst_busy,
  output logic                wdt_fired
);

  localparam int CW = cnt_w(HOLD_CYC, STAGE_DLY);

  logic                w_srst_n;
  rst_state_e          r_state;
  rst_state_e          w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [N_STAGES-1:0] r_rel;
  logic [N_STAGES-1:0] w_rel_nxt;
  logic                w_expire;
  logic                w_reseq;

  ice40_rst_sync u_sync (
    .clk      (clk),
    .i_arst_n (resetn),
    .o_srst_n (w_srst_n)
  );

`ifdef ICE40_RST_WDT_EN
  localparam int WW = cnt_w(WDT_CYC, 1);

  logic [WW-1:0] r_wdt;
  logic [WW-1:0] w_wdt_nxt;
  logic          r_fired;

  // A kick on the expiry edge suppresses the expiry.
  assign w_expire = (r_state == S_DONE) && !wdt_kick &&
                    (r_wdt == WW'(WDT_CYC - 1));

  always_comb begin
    w_wdt_nxt = '0;
    if ((r_state == S_DONE) && !wdt_kick &&
        !w_expire && !sw_rst_req)
      w_wdt_nxt = r_wdt + 1'b1;
  end

  always_ff @(posedge clk or negedge w_srst_n) begin
    if (!w_srst_n) begin
      r_wdt   <= '0;
      r_fired <= 1'b0;
    end else begin
      r_wdt <= w_wdt_nxt;
      if (w_expire)
        r_fired <= 1'b1;
    end
  end

  assign wdt_fired = r_fired;
`else
  localparam int unused_wdt_cyc = WDT_CYC;
  logic w_unused_kick;
  assign w_unused_kick = wdt_kick;
  assign w_expire      = 1'b0;
  assign wdt_fired     = 1'b0;
`endif

  assign w_reseq = sw_rst_req || w_expire;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rel_nxt   = r_rel;
    unique case (r_state)
      S_HOLD: begin
        if (r_cnt == CW'(HOLD_CYC - 1)) begin
          w_rel_nxt[0] = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_STAGE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STAGE: begin
        // Released bits are contiguous from bit 0, so the top bit
        // marks completion and a shift-in releases the next one.
        if (r_rel[N_STAGES-1]) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else if (r_cnt == CW'(STAGE_DLY - 1)) begin
          w_rel_nxt = r_rel | (r_rel << 1);
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (w_reseq) begin
          w_rel_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_rel_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_srst_n) begin
    if (!w_srst_n) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_rel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rel   <= w_rel_nxt;
    end
  end

  assign rst_n_out = r_rel;
  assign rst_done  = (r_state == S_DONE);
  assign rst_busy  = (r_state != S_DONE);

endmodule
